instr_queue: RTL

INSTR_QUEUE -- requirements
Module: instr_queue

---
 rtl/tpu_pkg.sv | 28 ++
 rtl/sync_fifo.sv | 57 +++++
 rtl/instr_queue.sv | 70 +++++++
 3 files changed

// File: rtl/tpu_pkg.sv
// Shared TPU types: host word, decoded instruction and the 80-bit unpacking helper.
// Latency: n/a (types and a pure function). Backpressure: n/a.
// INSTR_WORDS host words make up one instruction.
package tpu_pkg;

  localparam int INSTR_WORDS = 3;
  localparam int INSTR_BITS  = 80;

  typedef logic [31:0] word_type;

  // Field order MSB-first, so the packed layout matches the raw 80-bit assembly.
  typedef struct packed {
    logic [23:0] buff_addr;
    logic [15:0] acc_addr;
    logic [31:0] length;
    logic [7:0]  opcode;
  } instr_type;

  function automatic instr_type bit_to_instr(input logic [INSTR_BITS-1:0] b);
    instr_type t;
    t.buff_addr = b[79:56];
    t.acc_addr  = b[55:40];
    t.length    = b[39:8];
    t.opcode    = b[7:0];
    return t;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage; head is read straight from storage.
// Latency: push visible at the head one cycle later. Backpressure: push ignored when full, pop ignored when empty.
// clear and rst_n flush pointers and count; storage contents are never reset.
module sync_fifo #(
  parameter int WIDTH = 80,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_dat,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign push_ok = push && !full && !clear;
  assign pop_ok  = pop && !empty && !clear;
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_dat;
  end

  // Power-of-two depth: pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_queue.sv
// Assembles three 32-bit host words into one 80-bit instruction and queues it for the control unit.
// Latency: third accepted word to instr_valid is 1 cycle. Backpressure: wr_ready drops only on the final word while full.
// A pop in the same cycle does not reopen wr_ready; clear beats both write and pop.
module instr_queue
  import tpu_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear,
  input  logic                          wr_en,
  input  word_type                      wr_data,
  output logic                          wr_ready,
  output logic                          instr_valid,
  output instr_type                     instr,
  input  logic                          instr_ready,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          full,
  output logic                          empty
);

  logic [1:0]            word_idx;
  word_type              stage0;
  word_type              stage1;
  logic                  last_word;
  logic                  accept;
  logic                  push;
  logic [INSTR_BITS-1:0] push_dat;
  logic [INSTR_BITS-1:0] head_dat;

  assign last_word   = (word_idx == 2'(INSTR_WORDS - 1));
  assign wr_ready    = !(last_word && full);
  assign accept      = wr_en && wr_ready && !clear;
  assign push        = accept && last_word;
  assign push_dat    = {wr_data[15:0], stage1, stage0};
  assign instr       = bit_to_instr(head_dat);
  assign instr_valid = !empty;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      word_idx <= '0;
    end else if (accept) begin
      word_idx <= last_word ? 2'd0 : word_idx + 2'd1;
    end
  end

  // Partial words never reach the FIFO, so instr cannot show a half-built instruction.
  always_ff @(posedge clk) begin
    if (accept && word_idx == 2'd0) stage0 <= wr_data;
    if (accept && word_idx == 2'd1) stage1 <= wr_data;
  end

  sync_fifo #(
    .WIDTH (INSTR_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .push     (push),
    .push_dat (push_dat),
    .pop      (instr_ready),
    .pop_dat  (head_dat),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

endmodule
